// File: rtl/tow_sfx_sequencer.sv
// Sound-effect sequencer: turns round-start / win events into timed tone requests
// (half-period + enable) for the speaker driver. Optional mute input via TOW_SFX_MUTE_EN.
module tow_sfx_sequencer #(
    parameter int CLK_HZ  = 100000000,
    parameter int NOTE_MS = 150,
    parameter int GAP_MS  = 30
) (
    input  logic        CLK_I,
    input  logic        rst,
    input  logic        evt_start,
    input  logic        evt_win_l,
    input  logic        evt_win_r,
`ifdef TOW_SFX_MUTE_EN
    input  logic        mute,
`endif
    output logic        spk_en,
    output logic [17:0] spk_half_period,
    output logic        busy,
    output logic [1:0]  seq_id
);

    localparam longint NOTE_CYC = longint'(CLK_HZ) / 1000 * longint'(NOTE_MS);
    localparam longint GAP_CYC  = longint'(CLK_HZ) / 1000 * longint'(GAP_MS);
    localparam longint CNT_MAX  = 64'd16777215;
    localparam bit     HAS_GAP  = (GAP_CYC != 0);

    localparam logic [23:0] NOTE_LOAD = 24'(NOTE_CYC - 1);
    localparam logic [23:0] GAP_LOAD  = HAS_GAP ? 24'(GAP_CYC - 1) : 24'd0;

    if (NOTE_CYC < 1 || NOTE_CYC > CNT_MAX) begin : g_bad_note
        $error("tow_sfx_sequencer: NOTE_CYC out of 24-bit counter range");
    end
    if (GAP_CYC < 0 || GAP_CYC > CNT_MAX) begin : g_bad_gap
        $error("tow_sfx_sequencer: GAP_CYC out of 24-bit counter range");
    end

    function automatic logic [17:0] hp(input int f);
        hp = 18'(CLK_HZ / (2 * f));
    endfunction

    localparam logic [17:0] HP700 = hp(700);
    localparam logic [17:0] HP523 = hp(523);
    localparam logic [17:0] HP659 = hp(659);
    localparam logic [17:0] HP784 = hp(784);

    localparam logic [1:0] SEQ_NONE  = 2'd0;
    localparam logic [1:0] SEQ_START = 2'd1;
    localparam logic [1:0] SEQ_WIN_L = 2'd2;
    localparam logic [1:0] SEQ_WIN_R = 2'd3;

    // Melody table: half-period of note n of sequence sid.
    function automatic logic [17:0] note_hp(input logic [1:0] sid, input logic [1:0] n);
        case (sid)
            SEQ_START: note_hp = HP700;
            SEQ_WIN_L: note_hp = (n == 2'd0) ? HP523 : (n == 2'd1) ? HP659 : HP784;
            SEQ_WIN_R: note_hp = (n == 2'd0) ? HP784 : (n == 2'd1) ? HP659 : HP523;
            default:   note_hp = 18'd0;
        endcase
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] sid);
        last_idx = (sid == SEQ_START) ? 2'd0 : 2'd2;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  seq_q, seq_d;
    logic [17:0] hp_q, hp_d;
    logic        en_q, en_d;
    logic [1:0]  evt_sid;

    always_ff @(posedge CLK_I) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 24'd0;
            idx_q   <= 2'd0;
            seq_q   <= SEQ_NONE;
            hp_q    <= 18'd0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            hp_q    <= hp_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        if (evt_win_l)      evt_sid = SEQ_WIN_L;
        else if (evt_win_r) evt_sid = SEQ_WIN_R;
        else if (evt_start) evt_sid = SEQ_START;
        else                evt_sid = SEQ_NONE;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        hp_d    = hp_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (evt_sid != SEQ_NONE) begin
                    state_d = NOTE;
                    idx_d   = 2'd0;
                    seq_d   = evt_sid;
                    hp_d    = note_hp(evt_sid, 2'd0);
                    en_d    = 1'b1;
                    cnt_d   = NOTE_LOAD;
                end
            end
            NOTE: begin
                if (cnt_q != 24'd0) begin
                    cnt_d = cnt_q - 24'd1;
                end else if (idx_q == last_idx(seq_q)) begin
                    // Half-period is left as-is so the driver never sees a glitch.
                    state_d = IDLE;
                    idx_d   = 2'd0;
                    seq_d   = SEQ_NONE;
                    en_d    = 1'b0;
                end else if (HAS_GAP) begin
                    state_d = GAP;
                    en_d    = 1'b0;
                    cnt_d   = GAP_LOAD;
                end else begin
                    idx_d = idx_q + 2'd1;
                    hp_d  = note_hp(seq_q, idx_q + 2'd1);
                    cnt_d = NOTE_LOAD;
                end
            end
            GAP: begin
                if (cnt_q != 24'd0) begin
                    cnt_d = cnt_q - 24'd1;
                end else begin
                    state_d = NOTE;
                    idx_d   = idx_q + 2'd1;
                    hp_d    = note_hp(seq_q, idx_q + 2'd1);
                    en_d    = 1'b1;
                    cnt_d   = NOTE_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                seq_d   = SEQ_NONE;
                en_d    = 1'b0;
            end
        endcase
    end

`ifdef TOW_SFX_MUTE_EN
    assign spk_en = en_q & ~mute;
`else
    assign spk_en = en_q;
`endif
    assign spk_half_period = hp_q;
    assign busy            = (state_q != IDLE);
    assign seq_id          = seq_q;

endmodule

// File: tb/tb_tow_sfx_sequencer.sv
// Self-checking bench for tow_sfx_sequencer: directed scenarios plus random events,
// compared every cycle against a timeline model of the melodies.
module tb_tow_sfx_sequencer;

    localparam int CLK_HZ  = 10000;
    localparam int NOTE_MS = 3;
    localparam int GAP_MS  = 1;
    localparam int NOTE    = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAP     = CLK_HZ / 1000 * GAP_MS;
    localparam int PERIOD  = NOTE + GAP;

    logic        CLK_I = 1'b0;
    logic        rst = 1'b1;
    logic        evt_start = 1'b0;
    logic        evt_win_l = 1'b0;
    logic        evt_win_r = 1'b0;
`ifdef TOW_SFX_MUTE_EN
    logic        mute = 1'b0;
`endif
    logic        spk_en;
    logic [17:0] spk_half_period;
    logic        busy;
    logic [1:0]  seq_id;

    int vecs = 0;
    int errs = 0;

    tow_sfx_sequencer #(.CLK_HZ(CLK_HZ), .NOTE_MS(NOTE_MS), .GAP_MS(GAP_MS)) dut (
        .CLK_I(CLK_I),
        .rst(rst),
        .evt_start(evt_start),
        .evt_win_l(evt_win_l),
        .evt_win_r(evt_win_r),
`ifdef TOW_SFX_MUTE_EN
        .mute(mute),
`endif
        .spk_en(spk_en),
        .spk_half_period(spk_half_period),
        .busy(busy),
        .seq_id(seq_id)
    );

    always #5 CLK_I = ~CLK_I;

    // ---------------- reference model: melody as a timeline ----------------
    function automatic int freq(input int s, input int n);
        case (s)
            1: return 700;
            2: return (n == 0) ? 523 : (n == 1) ? 659 : 784;
            3: return (n == 0) ? 784 : (n == 1) ? 659 : 523;
            default: return 0;
        endcase
    endfunction

    function automatic int mel_len(input int s);
        return (s == 1) ? 1 : 3;
    endfunction

    function automatic logic [17:0] ref_hp(input int s, input int n);
        return 18'(CLK_HZ / (2 * freq(s, n)));
    endfunction

    function automatic int seq_cycles(input int s);
        return mel_len(s) * NOTE + (mel_len(s) - 1) * GAP;
    endfunction

    int          m_seq = 0;
    int          m_t = 0;
    logic [17:0] m_hp = 18'd0;

    always @(posedge CLK_I) begin
        if (rst) begin
            m_seq <= 0;
            m_t   <= 0;
            m_hp  <= 18'd0;
        end else if (m_seq != 0) begin
            if (m_t + 1 >= seq_cycles(m_seq)) begin
                m_seq <= 0;
                m_hp  <= ref_hp(m_seq, mel_len(m_seq) - 1);
            end else begin
                m_t <= m_t + 1;
            end
        end else if (evt_win_l || evt_win_r || evt_start) begin
            m_seq <= evt_win_l ? 2 : evt_win_r ? 3 : 1;
            m_t   <= 0;
        end
    end

    // {spk_en, spk_half_period, busy, seq_id}
    function automatic logic [21:0] exp_vec();
        int   n;
        logic e;
        if (m_seq == 0) return {1'b0, m_hp, 1'b0, 2'b00};
        n = m_t / PERIOD;
        e = (m_t % PERIOD) < NOTE;
`ifdef TOW_SFX_MUTE_EN
        e = e & ~mute;
`endif
        return {e, ref_hp(m_seq, n), 1'b1, 2'(m_seq)};
    endfunction

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vecs++;
        if ({spk_en, spk_half_period, busy, seq_id} !== 22'd0) begin
            errs++;
            $display("FAIL reset got=%h exp=%h", {spk_en, spk_half_period, busy, seq_id}, 22'd0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_start();
        int en_cnt = 0;
        evt_start = 1'b1;
        tick();
        evt_start = 1'b0;
        vecs++;
        if (spk_half_period !== 18'd7 || seq_id !== 2'd1) begin
            errs++;
            $display("FAIL start_first hp=%0d seq=%0d exp hp=7 seq=1", spk_half_period, seq_id);
        end
        for (int i = 0; i < 40; i++) begin
            en_cnt += spk_en;
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL start cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
            tick();
        end
        vecs++;
        if (en_cnt != NOTE) begin
            errs++;
            $display("FAIL start_len got=%0d exp=%0d", en_cnt, NOTE);
        end
    endtask

    task automatic test_win_l();
        int en_cnt = 0;
        int busy_cnt = 0;
        evt_win_l = 1'b1;
        tick();
        evt_win_l = 1'b0;
        for (int i = 0; i < 120; i++) begin
            en_cnt   += spk_en;
            busy_cnt += busy;
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL win_l cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
            tick();
        end
        vecs++;
        if (busy_cnt != 110 || en_cnt != 90) begin
            errs++;
            $display("FAIL win_l_len busy=%0d en=%0d exp busy=110 en=90", busy_cnt, en_cnt);
        end
    endtask

    task automatic test_simultaneous();
        evt_win_r = 1'b1;
        evt_start = 1'b1;
        tick();
        evt_win_r = 1'b0;
        evt_start = 1'b0;
        vecs++;
        if (seq_id !== 2'd3 || spk_half_period !== 18'd6) begin
            errs++;
            $display("FAIL simul_first seq=%0d hp=%0d exp seq=3 hp=6", seq_id, spk_half_period);
        end
        for (int i = 0; i < 115; i++) begin
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL simul cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_ignore_busy();
        evt_win_l = 1'b1;
        tick();
        evt_win_l = 1'b0;
        for (int i = 0; i < 120; i++) begin
            // start mid-melody and again right on the final-note edge
            evt_start = (i == 14 || i == 109);
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL ignore cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
            tick();
        end
        evt_start = 1'b0;
        vecs++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL ignore_end busy=%0d exp=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        evt_win_l = 1'b1;
        tick();
        evt_win_l = 1'b0;
        repeat (PERIOD + 12) tick();
        vecs++;
        if (spk_en !== 1'b1 || spk_half_period !== 18'd7) begin
            errs++;
            $display("FAIL mid_pre en=%0d hp=%0d exp en=1 hp=7", spk_en, spk_half_period);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++;
        if ({spk_en, spk_half_period, busy, seq_id} !== 22'd0) begin
            errs++;
            $display("FAIL mid_reset got=%h exp=0", {spk_en, spk_half_period, busy, seq_id});
        end
        tick();
        evt_start = 1'b1;
        tick();
        evt_start = 1'b0;
        for (int i = 0; i < 35; i++) begin
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL mid_restart cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
            tick();
        end
    endtask

`ifdef TOW_SFX_MUTE_EN
    task automatic test_mute();
        int en_cnt = 0;
        int busy_cnt = 0;
        mute = 1'b1;
        evt_win_l = 1'b1;
        tick();
        evt_win_l = 1'b0;
        for (int i = 0; i < 115; i++) begin
            en_cnt   += spk_en;
            busy_cnt += busy;
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL mute cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
            tick();
        end
        mute = 1'b0;
        vecs++;
        if (en_cnt != 0 || busy_cnt != 110 || spk_half_period !== 18'd6) begin
            errs++;
            $display("FAIL mute_sum en=%0d busy=%0d hp=%0d exp en=0 busy=110 hp=6", en_cnt, busy_cnt, spk_half_period);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            evt_win_l = ($urandom_range(0, 39) == 0);
            evt_win_r = ($urandom_range(0, 39) == 0);
            evt_start = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 299) == 0);
`ifdef TOW_SFX_MUTE_EN
            if ($urandom_range(0, 49) == 0) mute = ~mute;
`endif
            tick();
            vecs++;
            if ({spk_en, spk_half_period, busy, seq_id} !== exp_vec()) begin
                errs++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, {spk_en, spk_half_period, busy, seq_id}, exp_vec());
            end
        end
        evt_win_l = 1'b0;
        evt_win_r = 1'b0;
        evt_start = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_win_l();
        test_simultaneous();
        test_ignore_busy();
        test_reset_mid();
`ifdef TOW_SFX_MUTE_EN
        repeat (5) tick();
        test_mute();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
